// File: rtl/wbuf_pkg.sv
// Shared types and helpers for the ping-pong weight buffer.
//   state_t   : stream controller states
//   NUM_BANKS : number of ping-pong banks per lane
//   lane_lsb  : bit offset of a lane inside a packed row / lane bus
package wbuf_pkg;

    localparam int unsigned NUM_BANKS = 2;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DRAIN,
        DONE
    } state_t;

    function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned width);
        return lane * width;
    endfunction

endpackage

// File: rtl/wbuf_lane_bank.sv
// One weight lane's storage: NUM_BANKS * RAM_SIZE words of WGT_WIDTH bits,
// addressed as {bank, row}.
// Ports:
//   clk, reset               clock, synchronous active-high reset (read register only)
//   wr_en/wr_bank/wr_addr/wr_data  single write port
//   rd_en/rd_bank/rd_addr    registered read request
//   rd_data                  read word one cycle after request, 0 when no request
module wbuf_lane_bank
    import wbuf_pkg::*;
#(
    parameter int RAM_SIZE   = 256,
    parameter int ADDR_WIDTH = $clog2(RAM_SIZE),
    parameter int WGT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic                  wr_bank,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [WGT_WIDTH-1:0]  wr_data,
    input  logic                  rd_en,
    input  logic                  rd_bank,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [WGT_WIDTH-1:0]  rd_data
);

    logic [WGT_WIDTH-1:0] mem [NUM_BANKS * RAM_SIZE];

    // Contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[{wr_bank, wr_addr}] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[{rd_bank, rd_addr}];
        end else begin
            rd_data <= '0;
        end
    end

endmodule

// File: rtl/wgt_buffer_pingpong.sv
// Ping-pong weight buffer feeding ARRAY_M systolic-array columns.
// The fill bank (~rd_bank) is written row by row; the read bank streams to the
// array either aligned or skewed (lane j delayed j cycles).
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   wr_en, wr_addr, wr_data    row write into the fill bank
//   swap                       bank exchange request (deferred to DONE while busy)
//   start, mode, base_addr,
//   num_rows, num_cols         stream request, sampled only in IDLE
//   wgt_data_set_out, wgt_valid  per-lane data / valid to the array
//   busy, done, rd_bank        status
module wgt_buffer_pingpong
    import wbuf_pkg::*;
#(
    parameter int RAM_SIZE        = 256,
    parameter int ADDR_WIDTH      = $clog2(RAM_SIZE),
    parameter int ARRAY_N         = 8,
    parameter int ARRAY_M         = 8,
    parameter int WGT_WIDTH       = 8,
    parameter int WBUF_DATA_WIDTH = ARRAY_M * WGT_WIDTH
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         wr_en,
    input  logic [ADDR_WIDTH-1:0]        wr_addr,
    input  logic [WBUF_DATA_WIDTH-1:0]   wr_data,
    input  logic                         swap,
    input  logic                         start,
    input  logic                         mode,
    input  logic [ADDR_WIDTH-1:0]        base_addr,
    input  logic [ADDR_WIDTH:0]          num_rows,
    input  logic [$clog2(ARRAY_M):0]     num_cols,
    output logic [WBUF_DATA_WIDTH-1:0]   wgt_data_set_out,
    output logic [ARRAY_M-1:0]           wgt_valid,
    output logic                         busy,
    output logic                         done,
    output logic                         rd_bank
);

    localparam int COL_W = $clog2(ARRAY_M) + 1;
    // Stream length reaches RAM_SIZE + ARRAY_M - 1.
    localparam int T_W   = ADDR_WIDTH + 2;

    // ARRAY_N only documents the array shape.
    if (ARRAY_N < 1) begin : g_array_n_unused
    end

    state_t                 state_q, state_d;
    logic [T_W-1:0]         t_q, t_d, len_q, len_d;
    logic [ADDR_WIDTH-1:0]  base_q, base_d;
    logic                   mode_q, mode_d;
    logic [ADDR_WIDTH:0]    rows_q, rows_d;
    logic [COL_W-1:0]       cols_q, cols_d, eff_cols;
    logic                   rd_bank_q, rd_bank_d;
    logic                   swap_pend_q, swap_pend_d;
    logic [ARRAY_M-1:0]     lane_en, valid_q;

    assign eff_cols = (num_cols > COL_W'(ARRAY_M)) ? COL_W'(ARRAY_M) : num_cols;

    always_comb begin
        state_d     = state_q;
        t_d         = t_q;
        len_d       = len_q;
        base_d      = base_q;
        mode_d      = mode_q;
        rows_d      = rows_q;
        cols_d      = cols_q;
        rd_bank_d   = rd_bank_q;
        swap_pend_d = swap_pend_q;
        case (state_q)
            IDLE: begin
                if (swap) begin
                    rd_bank_d = ~rd_bank_q;
                end
                if (start) begin
                    base_d = base_addr;
                    mode_d = mode;
                    rows_d = num_rows;
                    cols_d = eff_cols;
                    t_d    = '0;
                    len_d  = T_W'(num_rows) + (mode ? T_W'(eff_cols) - T_W'(1) : T_W'(0));
                    // An empty stream skips STREAM so done still lands 2 cycles after start.
                    if (num_rows == '0 || eff_cols == '0) begin
                        state_d = DRAIN;
                    end else begin
                        state_d = STREAM;
                    end
                end
            end
            STREAM: begin
                t_d = t_q + T_W'(1);
                if (t_q == len_q - T_W'(1)) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                state_d = DONE;
            end
            DONE: begin
                state_d     = IDLE;
                swap_pend_d = 1'b0;
                if (swap || swap_pend_q) begin
                    rd_bank_d = ~rd_bank_q;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (swap && (state_q == STREAM || state_q == DRAIN)) begin
            swap_pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            t_q         <= '0;
            len_q       <= '0;
            base_q      <= '0;
            mode_q      <= 1'b0;
            rows_q      <= '0;
            cols_q      <= '0;
            rd_bank_q   <= 1'b0;
            swap_pend_q <= 1'b0;
            valid_q     <= '0;
        end else begin
            state_q     <= state_d;
            t_q         <= t_d;
            len_q       <= len_d;
            base_q      <= base_d;
            mode_q      <= mode_d;
            rows_q      <= rows_d;
            cols_q      <= cols_d;
            rd_bank_q   <= rd_bank_d;
            swap_pend_q <= swap_pend_d;
            valid_q     <= lane_en;
        end
    end

    for (genvar j = 0; j < ARRAY_M; j++) begin : g_lane
        logic [T_W-1:0]        lane_d;
        logic [T_W-1:0]        lane_rel;
        logic [ADDR_WIDTH-1:0] lane_addr;

        assign lane_d     = mode_q ? T_W'(j) : T_W'(0);
        assign lane_rel   = t_q - lane_d;
        assign lane_en[j] = (state_q == STREAM) && (COL_W'(j) < cols_q) &&
                            (t_q >= lane_d) && (lane_rel < T_W'(rows_q));
        // Row address wraps modulo RAM_SIZE by truncation.
        assign lane_addr  = base_q + lane_rel[ADDR_WIDTH-1:0];

        wbuf_lane_bank #(
            .RAM_SIZE   (RAM_SIZE),
            .ADDR_WIDTH (ADDR_WIDTH),
            .WGT_WIDTH  (WGT_WIDTH)
        ) u_bank (
            .clk     (clk),
            .reset   (reset),
            .wr_en   (wr_en),
            .wr_bank (~rd_bank_q),
            .wr_addr (wr_addr),
            .wr_data (wr_data[lane_lsb(j, WGT_WIDTH) +: WGT_WIDTH]),
            .rd_en   (lane_en[j]),
            .rd_bank (rd_bank_q),
            .rd_addr (lane_addr),
            .rd_data (wgt_data_set_out[lane_lsb(j, WGT_WIDTH) +: WGT_WIDTH])
        );
    end

    assign wgt_valid = valid_q;
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign rd_bank   = rd_bank_q;

endmodule

// File: tb/tb_wgt_buffer_pingpong.sv
module tb_wgt_buffer_pingpong;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        wr_en = 1'b0;
    logic [7:0]  wr_addr = '0;
    logic [63:0] wr_data = '0;
    logic        swap = 1'b0;
    logic        start = 1'b0;
    logic        mode = 1'b0;
    logic [7:0]  base_addr = '0;
    logic [8:0]  num_rows = '0;
    logic [3:0]  num_cols = '0;
    logic [63:0] wgt_data_set_out;
    logic [7:0]  wgt_valid;
    logic        busy, done, rd_bank;

    wgt_buffer_pingpong dut (
        .clk              (clk),
        .reset            (reset),
        .wr_en            (wr_en),
        .wr_addr          (wr_addr),
        .wr_data          (wr_data),
        .swap             (swap),
        .start            (start),
        .mode             (mode),
        .base_addr        (base_addr),
        .num_rows         (num_rows),
        .num_cols         (num_cols),
        .wgt_data_set_out (wgt_data_set_out),
        .wgt_valid        (wgt_valid),
        .busy             (busy),
        .done             (done),
        .rd_bank          (rd_bank)
    );

    always #5 clk = ~clk;

    // Behavioural model: the stream is described only by its start cycle and
    // parameters; expected outputs of any cycle follow arithmetically.
    typedef struct {
        bit have;
        int s;
        int base;
        int mode;
        int rows;
        int ec;
        int bank;
        int len;
    } stream_t;

    logic [63:0] ref_mem [2][256];
    stream_t cur, nxt;
    int  m_bank = 0, m_pend = 0, nx_bank = 0, nx_pend = 0;
    int  cyc = 0;
    bit  chk_en = 1'b0;
    int  n_cmp = 0, n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
        end
    endtask

    function automatic bit in_busy(input stream_t st, input int n);
        return st.have && n >= st.s + 1 && n <= st.s + st.len + 2;
    endfunction

    task automatic model_step();
        int n;
        bit bz, dn;
        n = cyc;
        nxt = cur;
        nx_bank = m_bank;
        nx_pend = m_pend;
        if (wr_en) ref_mem[m_bank == 1 ? 0 : 1][wr_addr] = wr_data;
        if (reset) begin
            nx_bank = 0;
            nx_pend = 0;
            nxt.have = 1'b0;
            return;
        end
        bz = in_busy(cur, n);
        dn = cur.have && (n == cur.s + cur.len + 2);
        if (!bz) begin
            if (swap) nx_bank = 1 - m_bank;
        end else if (dn) begin
            if (swap || m_pend != 0) nx_bank = 1 - m_bank;
            nx_pend = 0;
        end else if (swap) begin
            nx_pend = 1;
        end
        if (!bz && start) begin
            nxt.have = 1'b1;
            nxt.s    = n;
            nxt.base = int'(base_addr);
            nxt.mode = int'(mode);
            nxt.rows = int'(num_rows);
            nxt.ec   = (num_cols > 8) ? 8 : int'(num_cols);
            nxt.bank = nx_bank;
            if (nxt.rows == 0 || nxt.ec == 0) nxt.len = 0;
            else nxt.len = nxt.rows + (nxt.mode != 0 ? nxt.ec - 1 : 0);
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        cyc++;
        cur    = nxt;
        m_bank = nx_bank;
        m_pend = nx_pend;
        wr_en  = 1'b0;
        swap   = 1'b0;
        start  = 1'b0;
    endtask

    task automatic run_to(input int target);
        int guard;
        guard = 0;
        while (cyc < target && guard < 2000) begin
            tick();
            guard++;
        end
        if (cyc < target) begin
            n_cmp++;
            n_err++;
            $display("FAIL run_to cyc=%0d actual=%0d required=%0d", cyc, cyc, target);
        end
    endtask

    task automatic do_write(input int a, input logic [63:0] d);
        wr_en   = 1'b1;
        wr_addr = a[7:0];
        wr_data = d;
        tick();
    endtask

    task automatic do_start(input bit m, input int b, input int r, input int c, output int s);
        mode      = m;
        base_addr = b[7:0];
        num_rows  = r[8:0];
        num_cols  = c[3:0];
        start     = 1'b1;
        s         = cyc;
        tick();
    endtask

    function automatic logic [63:0] pat_row(input int r);
        logic [63:0] v;
        v = '0;
        for (int j = 0; j < 8; j++) v[j*8 +: 8] = 8'((16 * r + j) % 256);
        return v;
    endfunction

    function automatic logic [7:0] lane_of(input logic [63:0] bus, input int j);
        return bus[j*8 +: 8];
    endfunction

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            logic [63:0] e_data;
            logic [7:0]  e_valid;
            int d, r;
            e_data  = '0;
            e_valid = '0;
            for (int j = 0; j < 8; j++) begin
                d = (cur.mode != 0) ? j : 0;
                r = cyc - cur.s - 2 - d;
                if (cur.have && j < cur.ec && r >= 0 && r < cur.rows) begin
                    e_valid[j] = 1'b1;
                    e_data[j*8 +: 8] = ref_mem[cur.bank][(cur.base + r) % 256][j*8 +: 8];
                end
            end
            check("wgt_valid", 64'(wgt_valid), 64'(e_valid));
            check("wgt_data", wgt_data_set_out, e_data);
            check("busy", 64'(busy), 64'(in_busy(cur, cyc)));
            check("done", 64'(done), 64'(cur.have && cyc == cur.s + cur.len + 2));
            check("rd_bank", 64'(rd_bank), 64'(m_bank));
        end
    end

    initial begin
        int s, s2;
        logic [63:0] rv;
        cur = '{default: 0};
        nxt = cur;
        tick();
        tick();
        reset = 1'b0;
        chk_en = 1'b1;
        check("rst_valid", 64'(wgt_valid), 64'h0);
        check("rst_busy", 64'(busy), 64'h0);
        check("rst_rd_bank", 64'(rd_bank), 64'h0);

        // Fill both banks completely so no stream ever reads unknown rows.
        for (int b = 0; b < 2; b++) begin
            for (int a = 0; a < 256; a++) do_write(a, {$urandom, $urandom});
            swap = 1'b1;
            tick();
        end

        // Load and skewed stream.
        for (int r = 0; r < 8; r++) do_write(r, pat_row(r));
        do_write(254, pat_row(254));
        do_write(255, pat_row(255));
        swap = 1'b1;
        tick();
        check("lit_swap_bank", 64'(rd_bank), 64'h1);
        do_start(1'b1, 0, 8, 8, s);
        run_to(s + 5);
        check("lit_skew_l0", 64'(lane_of(wgt_data_set_out, 0)), 64'd48);
        check("lit_skew_l3", 64'(lane_of(wgt_data_set_out, 3)), 64'd3);
        check("lit_skew_v", 64'(wgt_valid), 64'h0f);
        run_to(s + 17);
        check("lit_skew_done", 64'(done), 64'h1);
        tick();

        // Aligned partial.
        do_start(1'b0, 0, 4, 3, s);
        run_to(s + 2);
        check("lit_al_v", 64'(wgt_valid), 64'h07);
        check("lit_al_l2", 64'(lane_of(wgt_data_set_out, 2)), 64'd2);
        run_to(s + 6);
        check("lit_al_done", 64'(done), 64'h1);
        tick();

        // Address wrap.
        do_start(1'b0, 254, 4, 8, s);
        run_to(s + 2);
        check("lit_wrap_254", 64'(lane_of(wgt_data_set_out, 0)), 64'd224);
        run_to(s + 4);
        check("lit_wrap_0", 64'(lane_of(wgt_data_set_out, 1)), 64'd1);
        run_to(s + 7);

        // Ping-pong: fill bank 0 and request swap during a bank-1 stream.
        do_start(1'b1, 0, 8, 8, s);
        while (cyc < s + 17) begin
            if (cyc - s <= 9) begin
                wr_en   = 1'b1;
                wr_addr = 8'(cyc - s);
                wr_data = {$urandom, $urandom};
            end
            if (cyc == s + 4) swap = 1'b1;
            if (cyc == s + 6) begin
                start     = 1'b1;
                mode      = 1'b0;
                base_addr = 8'd100;
                num_rows  = 9'd3;
            end
            tick();
        end
        check("lit_pp_done", 64'(done), 64'h1);
        check("lit_pp_bank_hold", 64'(rd_bank), 64'h1);
        tick();
        check("lit_pp_bank_flip", 64'(rd_bank), 64'h0);
        check("lit_pp_idle", 64'(busy), 64'h0);

        // Empty stream, then column clamp.
        do_start(1'b1, 0, 0, 8, s);
        run_to(s + 2);
        check("lit_empty_done", 64'(done), 64'h1);
        tick();
        do_start(1'b1, 3, 1, 15, s);
        run_to(s + 9);
        check("lit_clamp_v7", 64'(wgt_valid), 64'h80);
        run_to(s + 10);
        check("lit_clamp_done", 64'(done), 64'h1);
        tick();

        // Reset in the middle of a stream.
        do_start(1'b1, 0, 8, 8, s);
        run_to(s + 5);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("lit_rst_valid", 64'(wgt_valid), 64'h0);
        check("lit_rst_busy", 64'(busy), 64'h0);
        check("lit_rst_bank", 64'(rd_bank), 64'h0);
        do_start(1'b0, 10, 2, 8, s2);
        run_to(s2 + 4);
        check("lit_rst_restart", 64'(done), 64'h1);
        tick();

        // Randomized traffic.
        for (int i = 0; i < 4000; i++) begin
            reset     = ($urandom % 400 == 0);
            wr_en     = $urandom % 2;
            wr_addr   = 8'($urandom);
            rv        = {$urandom, $urandom};
            wr_data   = rv;
            swap      = ($urandom % 25 == 0);
            start     = ($urandom % 6 == 0);
            mode      = $urandom % 2;
            base_addr = 8'($urandom);
            num_rows  = ($urandom % 10 == 0) ? 9'($urandom_range(0, 256))
                                              : 9'($urandom_range(0, 12));
            num_cols  = 4'($urandom_range(0, 15));
            tick();
            reset = 1'b0;
        end
        for (int i = 0; i < 300; i++) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
